// File: rtl/systolic_array_n_if.sv
// Operand-in / result-row-out bundle for systolic_array_n.
// Handshakes are strict valid/ready: a transfer happens on a rising edge where
// valid && ready; valid never waits on ready, and payload is held until accepted.
interface systolic_array_n_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [N*DATA_W-1:0]   in_a;
    logic [N*DATA_W-1:0]   in_b;
    logic                  in_acc;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*ACC_W-1:0]    out_data;
    logic [ROW_W-1:0]      out_row;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic [1:0]            dbg_state;

    modport master (
        output in_valid, in_a, in_b, in_acc, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last, busy, done, dbg_state
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last, busy, done, dbg_state
    );
endinterface

// File: rtl/systolic_array_n.sv
// Output-stationary N x N systolic matrix multiplier: loads A columns / B rows,
// streams them skewed through a PE grid, then drains C one row at a time.
module systolic_array_n #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input logic              clk,
    input logic              reset,
    systolic_array_n_if.slave bus
);
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam int C_W   = $clog2(3 * N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;

    state_t                    r_state, w_next;
    logic [ROW_W-1:0]          r_k, r_row;
    logic [C_W-1:0]            r_c;
    logic                      r_done;
    logic [DATA_W-1:0]         r_a_buf [N][N];
    logic [DATA_W-1:0]         r_b_buf [N][N];
    logic [DATA_W-1:0]         r_a_pipe[N][N];
    logic [DATA_W-1:0]         r_b_pipe[N][N];
    logic [ACC_W-1:0]          r_acc   [N][N];
    logic [DATA_W-1:0]         w_a_in  [N][N];
    logic [DATA_W-1:0]         w_b_in  [N][N];
    logic signed [2*DATA_W-1:0] w_ps   [N][N];
    logic [2*DATA_W-1:0]       w_pu    [N][N];
    logic [ACC_W-1:0]          w_prod  [N][N];
    logic                      w_accept, w_comp_last, w_row_hs, w_last_row;

    always_comb begin
        w_accept    = bus.in_valid && (r_state == S_IDLE || r_state == S_LOAD);
        w_comp_last = (r_c == C_W'(3 * N - 2));
        w_last_row  = (r_row == ROW_W'(N - 1));
        w_row_hs    = (r_state == S_DRAIN) && bus.out_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (w_accept) w_next = S_LOAD;
            end
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (w_accept && r_k == ROW_W'(N - 1)) w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (w_comp_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_last  = w_last_row;
                if (w_row_hs && w_last_row) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k    <= '0;
            r_c    <= '0;
            r_row  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) r_k <= ROW_W'(1);
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_k == ROW_W'(N - 1)) begin
                            r_k <= '0;
                            r_c <= '0;
                        end else begin
                            r_k <= r_k + ROW_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (w_comp_last) begin
                        r_c   <= '0;
                        r_row <= '0;
                    end else begin
                        r_c <= r_c + C_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_row_hs) begin
                        if (w_last_row) begin
                            r_row  <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_row <= r_row + ROW_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Skewed edge injection: row i sees A[i][c-i], column j sees B[c-j][j].
    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                w_a_in[i][j] = '0;
                w_b_in[i][j] = '0;
            end
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++)
                if (r_state == S_COMPUTE && r_c == C_W'(i + k)) w_a_in[i][0] = r_a_buf[i][k];
            for (int j = 1; j < N; j++) w_a_in[i][j] = r_a_pipe[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++)
                if (r_state == S_COMPUTE && r_c == C_W'(j + k)) w_b_in[0][j] = r_b_buf[k][j];
            for (int i = 1; i < N; i++) w_b_in[i][j] = r_b_pipe[i-1][j];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                w_ps[i][j] = $signed({{DATA_W{w_a_in[i][j][DATA_W-1]}}, w_a_in[i][j]})
                           * $signed({{DATA_W{w_b_in[i][j][DATA_W-1]}}, w_b_in[i][j]});
                w_pu[i][j] = {{DATA_W{1'b0}}, w_a_in[i][j]} * {{DATA_W{1'b0}}, w_b_in[i][j]};
                if (SIGNED != 0) w_prod[i][j] = ACC_W'(w_ps[i][j]);
                else             w_prod[i][j] = ACC_W'(w_pu[i][j]);
            end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    r_a_buf[i][j]  <= '0;
                    r_b_buf[i][j]  <= '0;
                    r_a_pipe[i][j] <= '0;
                    r_b_pipe[i][j] <= '0;
                    r_acc[i][j]    <= '0;
                end
        end else begin
            if (w_accept) begin
                for (int k = 0; k < N; k++)
                    if (r_k == ROW_W'(k))
                        for (int i = 0; i < N; i++) begin
                            r_a_buf[i][k] <= bus.in_a[i*DATA_W +: DATA_W];
                            r_b_buf[k][i] <= bus.in_b[i*DATA_W +: DATA_W];
                        end
            end
            // in_acc only matters on the first beat of a job.
            if (r_state == S_IDLE && w_accept && !bus.in_acc) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) r_acc[i][j] <= '0;
            end
            if (r_state == S_COMPUTE) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        r_acc[i][j]    <= r_acc[i][j] + w_prod[i][j];
                        r_a_pipe[i][j] <= w_comp_last ? '0 : w_a_in[i][j];
                        r_b_pipe[i][j] <= w_comp_last ? '0 : w_b_in[i][j];
                    end
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        if (r_state == S_DRAIN)
            for (int i = 0; i < N; i++)
                if (r_row == ROW_W'(i))
                    for (int j = 0; j < N; j++) bus.out_data[j*ACC_W +: ACC_W] = r_acc[i][j];
    end

    assign bus.out_row   = r_row;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;
endmodule

// File: doc/systolic_array_n.md
SYSTOLIC_ARRAY_N -- requirements
Module: systolic_array_n

Interface
REQ-001 SHALL have parameter N, default 4, array dimension (legal 2..8).
REQ-002 SHALL have parameter DATA_W, default 8, operand element width.
REQ-003 SHALL have parameter ACC_W, default 32, accumulator width (>= 2*DATA_W).
REQ-004 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts an input beat.
REQ-009 in_a  input  N*DATA_W  column k of A; element i at bits [i*DATA_W +: DATA_W].
REQ-010 in_b  input  N*DATA_W  row k of B; element j at bits [j*DATA_W +: DATA_W].
REQ-011 in_acc  input  1  sampled on the first beat of a job: 1 = add to existing accumulators, 0 = clear first.
REQ-012 out_valid  output  1  result row valid.
REQ-013 out_ready  input  1  downstream accepts the result row.
REQ-014 out_data  output  N*ACC_W  C row r; element j at bits [j*ACC_W +: ACC_W].
REQ-015 out_row  output  $clog2(N)  index r of the row on out_data.
REQ-016 out_last  output  1  high with out_valid when r = N-1.
REQ-017 busy  output  1  high in LOAD, COMPUTE, DRAIN.
REQ-018 done  output  1  one-cycle pulse after the last row handshake.

Function
REQ-019 SHALL compute C = A x B (N x N) over one job; with in_acc=1, SHALL compute C = C_prev + A x B.
REQ-020 FSM states SHALL be IDLE, LOAD, COMPUTE, DRAIN.
REQ-021 in_ready SHALL be 1 in IDLE and LOAD, 0 otherwise; a beat is accepted when in_valid && in_ready.
REQ-022 IDLE: the first accepted beat is stored as k=0; in_acc sampled; if in_acc=0, all N*N accumulators cleared the same edge; -> LOAD (or COMPUTE if N=1 beat remaining is 0).
REQ-023 LOAD: each accepted beat is stored as k = 1..N-1; the Nth accepted beat moves the FSM to COMPUTE on the same edge.
REQ-024 COMPUTE SHALL last exactly 3N-1 cycles, counted by cycle counter c = 0..3N-2.
REQ-025 At cycle c, row i left edge SHALL inject A[i][c-i] and column j top edge B[c-j][j] when 0 <= c-i < N (resp. c-j), else 0.
REQ-026 Each PE SHALL register A rightward and B downward one cycle per hop, and add A*B to its accumulator every COMPUTE cycle.
REQ-027 Products SHALL be full 2*DATA_W width, sign- or zero-extended per SIGNED to ACC_W; accumulation wraps modulo 2^ACC_W, no saturation.
REQ-028 After c = 3N-2, FSM SHALL enter DRAIN with r = 0; inter-PE pipeline registers cleared.
REQ-029 DRAIN: out_valid=1, out_data = C row r, out_row = r; r increments on out_valid && out_ready; out_data stable while out_ready=0.
REQ-030 Handshake on r = N-1 SHALL move FSM to IDLE and pulse done for one cycle on the following cycle.
REQ-031 Accumulators SHALL retain values in IDLE, enabling tiled accumulation across jobs.
REQ-032 out_valid SHALL be 0 outside DRAIN; busy = (state != IDLE).
REQ-033 in_valid in COMPUTE/DRAIN SHALL be ignored (not consumed); out_ready outside DRAIN has no effect.

Reset
REQ-034 reset SHALL asynchronously force IDLE, clear operand buffers, accumulators, pipeline registers, counters; in_ready=1, out_valid=0, out_last=0, out_row=0, out_data=0, busy=0, done=0.
REQ-035 reset asserted mid-LOAD, COMPUTE or DRAIN SHALL abandon the job; no partial row emitted after release.

Verification
REQ-036 N=4, A=I, B[k][j]=4k+j+1, in_acc=0, out_ready=1 -> rows 0..3 = B rows, out_last on row 3, done 1 cycle later; in_ready to out_valid = 3N-1 cycles after the 4th beat.
REQ-037 N=4 all-ones A,B twice, second job in_acc=1 -> every C element 4 then 8.
REQ-038 SIGNED=1, A all -128, B all -128 (N=4) -> each element 65536; SIGNED=0 with 0xFF inputs -> 260100.
REQ-039 out_ready toggled 1,0,0,1 pattern during DRAIN -> out_data/out_row held while stalled, rows emitted 0..3 in order, no loss or duplication.
REQ-040 reset pulsed at COMPUTE c=5, then new job A=I, B=2I -> diagonal 2, off-diagonal 0 (no residue from aborted job).
REQ-041 N=2 and N=8 builds with random signed operands -> output matches reference model; COMPUTE lasts 5 and 23 cycles respectively.
